// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, issues one-word reads to a
// synchronous instruction memory and buffers returned words in a 2-entry FIFO
// that feeds the decoder through a valid/stall handshake. Branch redirects
// flush everything in flight; the all-ones halt word stops fetching.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflightAddr_q, inflightAddr_d;
  logic [1:0]        count_q, count_d;
  logic [31:0]       headWord_q, headWord_d;
  logic [ADDR_W-1:0] headAddr_q, headAddr_d;
  logic [31:0]       tailWord_q, tailWord_d;
  logic [ADDR_W-1:0] tailAddr_q, tailAddr_d;

  logic       pop;
  logic       push;
  logic       haltHit;
  logic       isHaltWord;
  logic       creditOk;
  logic       issue;
  logic       pushFull;
  logic [2:0] occupancy;

  // The decoder takes the head whenever it is valid and not stalled.
  assign pop        = (count_q != 2'd0) & ~stall;
  assign isHaltWord = (imem_rdata == HALT_WORD);
  assign haltHit    = inflight_q & (state_q == RUN) & isHaltWord;
  assign push       = inflight_q & (state_q == RUN) & ~isHaltWord;

  // Buffered plus outstanding words, less the one leaving this cycle, must
  // stay below the FIFO depth so a returning word always has a slot.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign creditOk  = occupancy < (3'd2 + {2'b00, pop});
  assign issue     = ~rst & (state_q == RUN) & en & ~branch_valid & creditOk;

  assign imem_req  = issue;
  assign imem_addr = fetchPc_q;

  assign instruction = headWord_q;
  assign pc          = headAddr_q;
  assign instr_valid = (count_q != 2'd0);
  assign halted      = (state_q == HALT) & (count_q == 2'd0);

  // Next-state logic: branch flushes everything, otherwise halt detection and the FIFO push/pop.
  always_comb begin
    state_d        = state_q;
    fetchPc_d      = fetchPc_q;
    inflight_d     = issue;
    inflightAddr_d = inflightAddr_q;
    count_d        = count_q;
    headWord_d     = headWord_q;
    headAddr_d     = headAddr_q;
    tailWord_d     = tailWord_q;
    tailAddr_d     = tailAddr_q;

    if (issue) begin
      fetchPc_d      = fetchPc_q + ADDR_W'(1);
      inflightAddr_d = fetchPc_q;
    end

    if (branch_valid) begin
      state_d    = RUN;
      fetchPc_d  = branch_target;
      inflight_d = 1'b0;
      count_d    = 2'd0;
      headWord_d = '0;
      headAddr_d = '0;
      tailWord_d = '0;
      tailAddr_d = '0;
    end else begin
      if (haltHit) begin
        state_d = HALT;
      end
      unique case ({push, pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            headWord_d = imem_rdata;
            headAddr_d = inflightAddr_q;
          end else begin
            headWord_d = tailWord_q;
            headAddr_d = tailAddr_q;
            tailWord_d = imem_rdata;
            tailAddr_d = inflightAddr_q;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            headWord_d = imem_rdata;
            headAddr_d = inflightAddr_q;
          end else begin
            tailWord_d = imem_rdata;
            tailAddr_d = inflightAddr_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          headWord_d = tailWord_q;
          headAddr_d = tailAddr_q;
          tailWord_d = '0;
          tailAddr_d = '0;
          count_d    = count_q - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers; reset clears everything at once, dropping any in-flight return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      fetchPc_q      <= RESET_PC;
      inflight_q     <= 1'b0;
      inflightAddr_q <= '0;
      count_q        <= 2'd0;
      headWord_q     <= '0;
      headAddr_q     <= '0;
      tailWord_q     <= '0;
      tailAddr_q     <= '0;
    end else begin
      state_q        <= state_d;
      fetchPc_q      <= fetchPc_d;
      inflight_q     <= inflight_d;
      inflightAddr_q <= inflightAddr_d;
      count_q        <= count_d;
      headWord_q     <= headWord_d;
      headAddr_q     <= headAddr_d;
      tailWord_q     <= tailWord_d;
      tailAddr_q     <= tailAddr_d;
    end
  end

  // A push into a full FIFO with no pop would mean the credit check is broken.
  assign pushFull = push & ~pop & ~branch_valid & (count_q == 2'd2);

  pushIntoFull: assert property (@(posedge clk) disable iff (rst) !pushFull);

endmodule
